// File: rtl/lmem_arbiter.sv
// Two-client arbiter for the layer memory: CONV engine (0) and host readout (1).
// Build option LMEM_ARB_RR_EN makes the IDLE tie-break round-robin instead of fixed priority to requester 0.
//
// state | meaning
// IDLE  | no owner, hold_cnt parked at 0
// OWN0  | CONV engine owns the memory port
// OWN1  | host readout owns the memory port
module lmem_arbiter #(
    parameter int MAX_HOLD = 64,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 20
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_req,
    input  logic              req0_lock,
    input  logic              req0_wr,
    input  logic [2:0]        req0_sel,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,

    input  logic              req1_req,
    input  logic              req1_lock,
    input  logic              req1_wr,
    input  logic [2:0]        req1_sel,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,

    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic              cwr,
    output logic              crd,
    output logic [2:0]        csel,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_wr,
    input  logic [DATA_W-1:0] cdata_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int              HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t            state;
    state_t            state_nxt;
    logic [HW-1:0]     hold_cnt;
    logic [HW-1:0]     hold_cnt_nxt;

    logic              acc0;
    logic              acc1;
    logic              acc;
    logic              acc_wr;
    logic [2:0]        acc_sel;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              tie_pick1;
    logic              rd_tag;

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);

    assign acc0 = gnt0 && req0_req;
    assign acc1 = gnt1 && req1_req;
    assign acc  = acc0 || acc1;

    assign acc_wr    = acc1 ? req1_wr    : req0_wr;
    assign acc_sel   = acc1 ? req1_sel   : req0_sel;
    assign acc_addr  = acc1 ? req1_addr  : req0_addr;
    assign acc_wdata = acc1 ? req1_wdata : req0_wdata;

`ifdef LMEM_ARB_RR_EN
    // last_gnt starts at 1 so requester 0 is favoured on the first tie after reset.
    logic last_gnt;

    assign tie_pick1 = ~last_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (state_nxt == OWN0) begin
            last_gnt <= 1'b0;
        end else if (state_nxt == OWN1) begin
            last_gnt <= 1'b1;
        end
    end
`else
    assign tie_pick1 = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0_req && req1_req) begin
                    state_nxt = tie_pick1 ? OWN1 : OWN0;
                end else if (req0_req) begin
                    state_nxt = OWN0;
                end else if (req1_req) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!req0_req && !req0_lock) begin
                    state_nxt = req1_req ? OWN1 : IDLE;
                end else if (!req0_lock && req1_req && acc0 && (hold_cnt == HOLD_LAST)) begin
                    state_nxt = OWN1;
                end
            end
            OWN1: begin
                if (!req1_req && !req1_lock) begin
                    state_nxt = req0_req ? OWN0 : IDLE;
                end else if (!req1_lock && req0_req && acc1 && (hold_cnt == HOLD_LAST)) begin
                    state_nxt = OWN0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counts commands of the current tenure; saturates so a locked owner never wraps.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if ((state == IDLE) || (state_nxt != state)) begin
            hold_cnt_nxt = '0;
        end else if (acc && (hold_cnt != HOLD_LAST)) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwr      <= 1'b0;
            crd      <= 1'b0;
            csel     <= '0;
            caddr_wr <= '0;
            caddr_rd <= '0;
            cdata_wr <= '0;
            rd_tag   <= 1'b0;
        end else begin
            cwr <= acc && acc_wr;
            crd <= acc && !acc_wr;
            if (acc) begin
                csel   <= acc_sel;
                rd_tag <= acc1;
            end
            if (acc && acc_wr) begin
                caddr_wr <= acc_addr;
                cdata_wr <= acc_wdata;
            end
            if (acc && !acc_wr) begin
                caddr_rd <= acc_addr;
            end
        end
    end

    // Read return is steered by the tag captured at issue, not by the current owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= crd && !rd_tag;
            rvalid1 <= crd && rd_tag;
            if (crd && !rd_tag) begin
                rdata0 <= cdata_rd;
            end
            if (crd && rd_tag) begin
                rdata1 <= cdata_rd;
            end
        end
    end

endmodule

// File: tb/tb_lmem_arbiter.sv
// Self-checking bench for lmem_arbiter (MAX_HOLD=4); expectations adapt to LMEM_ARB_RR_EN.
module tb_lmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 20;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_req, req0_lock, req0_wr;
    logic [2:0]    req0_sel;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_req, req1_lock, req1_wr;
    logic [2:0]    req1_sel;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          gnt0, rvalid0, gnt1, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          cwr, crd;
    logic [2:0]    csel;
    logic [AW-1:0] caddr_wr, caddr_rd;
    logic [DW-1:0] cdata_wr, cdata_rd;

    typedef struct {
        logic          wr;
        logic [2:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        logic          tag;
        logic [DW-1:0] data;
    } rd_t;

    cmd_t cmd_q[$];
    rd_t  rd_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return (a == 12'h3FF) ? 20'h12345 : {8'h5A, a};
    endfunction

    assign cdata_rd = crd ? mem_model(caddr_rd) : '0;

    lmem_arbiter #(.MAX_HOLD(MH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0_req(req0_req), .req0_lock(req0_lock), .req0_wr(req0_wr),
        .req0_sel(req0_sel), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_req(req1_req), .req1_lock(req1_lock), .req1_wr(req1_wr),
        .req1_sel(req1_sel), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .cwr(cwr), .crd(crd), .csel(csel), .caddr_wr(caddr_wr),
        .caddr_rd(caddr_rd), .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
    );

    // Scoreboard monitor: every memory command and read return must match the queued expectation.
    always begin : monitor
        cmd_t ec;
        rd_t  er;
        logic ok;
        @(negedge clk);
        #1;
        if (!reset) begin
            checks++;
            if ((gnt0 && gnt1) || (cwr && crd)) begin
                errors++;
                $display("FAIL exclusive: gnt0=%b gnt1=%b cwr=%b crd=%b, required no overlap", gnt0, gnt1, cwr, crd);
            end
            if (cwr || crd) begin
                checks++;
                if (cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected: cwr=%b crd=%b, required none", cwr, crd);
                end else begin
                    ec = cmd_q.pop_front();
                    if (ec.wr) ok = (cwr === 1'b1) && (csel === ec.sel) && (caddr_wr === ec.addr) && (cdata_wr === ec.data);
                    else       ok = (crd === 1'b1) && (csel === ec.sel) && (caddr_rd === ec.addr);
                    if (!ok) begin
                        errors++;
                        $display("FAIL cmd: got cwr=%b crd=%b sel=%h awr=%h ard=%h d=%h, required wr=%b sel=%h a=%h d=%h",
                                 cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr, ec.wr, ec.sel, ec.addr, ec.data);
                    end
                end
            end
            if (rvalid0 || rvalid1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected: rvalid0=%b rvalid1=%b, required none", rvalid0, rvalid1);
                end else begin
                    er = rd_q.pop_front();
                    ok = er.tag ? (rvalid1 === 1'b1 && rvalid0 === 1'b0 && rdata1 === er.data)
                                : (rvalid0 === 1'b1 && rvalid1 === 1'b0 && rdata0 === er.data);
                    if (!ok) begin
                        errors++;
                        $display("FAIL rvalid: got rv0=%b rv1=%b rd0=%h rd1=%h, required tag=%0d data=%h",
                                 rvalid0, rvalid1, rdata0, rdata1, er.tag, er.data);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_idle();
        req0_req = 0; req0_lock = 0; req0_wr = 0; req0_sel = '0; req0_addr = '0; req0_wdata = '0;
        req1_req = 0; req1_lock = 0; req1_wr = 0; req1_sel = '0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic drive0(input logic wr, input logic [2:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0_req = 1; req0_wr = wr; req0_sel = sel; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic wr, input logic [2:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1_req = 1; req1_wr = wr; req1_sel = sel; req1_addr = a; req1_wdata = d;
    endtask

    task automatic pulse_reset();
        cyc();
        #2 reset = 1;
        cyc();
        reset = 0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1;
        cyc(); cyc();
        checks++;
        if ({gnt0, gnt1, cwr, crd, rvalid0, rvalid1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 000000", {gnt0, gnt1, cwr, crd, rvalid0, rvalid1});
        end
        checks++;
        if ({csel, caddr_wr, caddr_rd, cdata_wr, rdata0, rdata1} !== '0) begin
            errors++;
            $display("FAIL reset_data: sel=%h awr=%h ard=%h dwr=%h rd0=%h rd1=%h, required all 0",
                     csel, caddr_wr, caddr_rd, cdata_wr, rdata0, rdata1);
        end
        reset = 0;
        cyc();
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: gnt=%b%b, required 00", gnt0, gnt1);
        end
    endtask

    task automatic test_write();
        drive0(1'b1, 3'b001, 12'h005, 20'h00ABC);
        cyc();
        checks++;
        if ({gnt0, gnt1, cwr} !== 3'b100) begin
            errors++;
            $display("FAIL write_grant: gnt0=%b gnt1=%b cwr=%b, required 1 0 0", gnt0, gnt1, cwr);
        end
        cmd_q.push_back('{1'b1, 3'b001, 12'h005, 20'h00ABC});
        cyc();
        checks++;
        if (cwr !== 1'b1 || crd !== 1'b0 || caddr_wr !== 12'h005 || cdata_wr !== 20'h00ABC || csel !== 3'b001) begin
            errors++;
            $display("FAIL write_cmd: cwr=%b crd=%b a=%h d=%h sel=%b, required 1 0 005 00abc 001",
                     cwr, crd, caddr_wr, cdata_wr, csel);
        end
        req0_req = 0;
        cyc();
        checks++;
        if (cwr !== 1'b0 || caddr_wr !== 12'h005 || cdata_wr !== 20'h00ABC || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL write_hold: cwr=%b a=%h d=%h gnt0=%b, required 0 005 00abc 0", cwr, caddr_wr, cdata_wr, gnt0);
        end
    endtask

    task automatic test_read1();
        drive1(1'b0, 3'b010, 12'h3FF, '0);
        cyc();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL read_grant: gnt=%b%b, required 01", gnt0, gnt1);
        end
        cmd_q.push_back('{1'b0, 3'b010, 12'h3FF, '0});
        rd_q.push_back('{1'b1, 20'h12345});
        cyc();
        checks++;
        if (crd !== 1'b1 || cwr !== 1'b0 || caddr_rd !== 12'h3FF || csel !== 3'b010) begin
            errors++;
            $display("FAIL read_cmd: crd=%b cwr=%b a=%h sel=%b, required 1 0 3ff 010", crd, cwr, caddr_rd, csel);
        end
        req1_req = 0;
        cyc();
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 20'h12345 || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL read_return: rv1=%b rd1=%h rv0=%b, required 1 12345 0", rvalid1, rdata1, rvalid0);
        end
        cyc();
        checks++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            errors++;
            $display("FAIL read_pulse: rv=%b%b, required 00", rvalid0, rvalid1);
        end
    endtask

    task automatic test_tie();
        logic exp1;
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            drive0(1'b0, 3'b000, 12'h001, '0);
            drive1(1'b0, 3'b000, 12'h002, '0);
            cyc();
`ifdef LMEM_ARB_RR_EN
            exp1 = (r == 1);
`else
            exp1 = 1'b0;
`endif
            checks++;
            if ({gnt0, gnt1} !== {~exp1, exp1}) begin
                errors++;
                $display("FAIL tie_round%0d: gnt=%b%b, required %b%b", r, gnt0, gnt1, ~exp1, exp1);
            end
            set_idle();
            cyc();
            checks++;
            if ({gnt0, gnt1} !== 2'b00) begin
                errors++;
                $display("FAIL tie_release%0d: gnt=%b%b, required 00", r, gnt0, gnt1);
            end
            cyc();
        end
    endtask

    task automatic test_preempt();
        pulse_reset();
        drive0(1'b1, 3'b100, 12'h100, 20'hA0000);
        drive1(1'b0, 3'b010, 12'h010, '0);
        cyc();
        for (int k = 0; k < MH; k++) begin
            checks++;
            if ({gnt0, gnt1} !== 2'b10) begin
                errors++;
                $display("FAIL preempt_hold%0d: gnt=%b%b, required 10", k, gnt0, gnt1);
            end
            drive0(1'b1, 3'b100, 12'h100 + 12'(k), 20'hA0000 + 20'(k));
            cmd_q.push_back('{1'b1, 3'b100, 12'h100 + 12'(k), 20'hA0000 + 20'(k)});
            cyc();
        end
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL preempt_switch: gnt=%b%b, required 01", gnt0, gnt1);
        end
        cmd_q.push_back('{1'b0, 3'b010, 12'h010, '0});
        rd_q.push_back('{1'b1, mem_model(12'h010)});
        req0_req = 0;
        cyc();
        req1_req = 0;
        cyc(); cyc(); cyc();

        drive0(1'b1, 3'b001, 12'h200, 20'hB0000);
        req0_lock = 1;
        drive1(1'b0, 3'b010, 12'h011, '0);
        cyc();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({gnt0, gnt1} !== 2'b10) begin
                errors++;
                $display("FAIL lock_hold%0d: gnt=%b%b, required 10", k, gnt0, gnt1);
            end
            drive0(1'b1, 3'b001, 12'h200 + 12'(k), 20'hB0000 + 20'(k));
            cmd_q.push_back('{1'b1, 3'b001, 12'h200 + 12'(k), 20'hB0000 + 20'(k)});
            cyc();
        end
        set_idle();
        cyc();
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++;
            $display("FAIL lock_release: gnt=%b%b, required 00", gnt0, gnt1);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        drive0(1'b0, 3'b001, 12'h020, '0);
        cyc();
        cmd_q.push_back('{1'b0, 3'b001, 12'h020, '0});
        cyc();
        checks++;
        if (crd !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_issue: crd=%b, required 1", crd);
        end
        #2 reset = 1;
        req0_req = 0;
        #1;
        checks++;
        if ({gnt0, gnt1, cwr, crd, rvalid0, rvalid1, csel, caddr_wr, caddr_rd, cdata_wr, rdata0, rdata1} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: gnt=%b%b cwr=%b crd=%b rv=%b%b sel=%h ard=%h rd0=%h, required all 0",
                     gnt0, gnt1, cwr, crd, rvalid0, rvalid1, csel, caddr_rd, rdata0);
        end
        cyc();
        reset = 0;
        drive1(1'b0, 3'b000, 12'h000, '0);
        cyc();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0100) begin
            errors++;
            $display("FAIL rstmid_resume: gnt=%b%b rv=%b%b, required 01 00", gnt0, gnt1, rvalid0, rvalid1);
        end
        req1_req = 0;
        cyc();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_quiet: gnt=%b%b rv=%b%b, required 0000", gnt0, gnt1, rvalid0, rvalid1);
        end
    endtask

    task automatic test_handover();
        drive0(1'b1, 3'b001, 12'h300, 20'hC0000);
        drive1(1'b0, 3'b101, 12'h060, '0);
        cyc();
        for (int k = 0; k < MH - 1; k++) begin
            checks++;
            if ({gnt0, gnt1} !== 2'b10) begin
                errors++;
                $display("FAIL b2b_grant%0d: gnt=%b%b, required 10", k, gnt0, gnt1);
            end
            drive0(1'b1, 3'b001, 12'h300 + 12'(k), 20'hC0000 + 20'(k));
            cmd_q.push_back('{1'b1, 3'b001, 12'h300 + 12'(k), 20'hC0000 + 20'(k)});
            cyc();
        end
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL handover_owner: gnt=%b%b, required 10", gnt0, gnt1);
        end
        drive0(1'b0, 3'b110, 12'h040, '0);
        cmd_q.push_back('{1'b0, 3'b110, 12'h040, '0});
        rd_q.push_back('{1'b0, mem_model(12'h040)});
        cyc();
        checks++;
        if ({gnt0, gnt1} !== 2'b01 || crd !== 1'b1 || caddr_rd !== 12'h040) begin
            errors++;
            $display("FAIL handover_switch: gnt=%b%b crd=%b a=%h, required 01 1 040", gnt0, gnt1, crd, caddr_rd);
        end
        req0_req = 0;
        cmd_q.push_back('{1'b0, 3'b101, 12'h060, '0});
        rd_q.push_back('{1'b1, mem_model(12'h060)});
        cyc();
        checks++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== mem_model(12'h040)) begin
            errors++;
            $display("FAIL handover_tag: rv0=%b rv1=%b rd0=%h, required 1 0 %h", rvalid0, rvalid1, rdata0, mem_model(12'h040));
        end
        req1_req = 0;
        cyc();
        checks++;
        if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== mem_model(12'h060)) begin
            errors++;
            $display("FAIL handover_r1: rv1=%b rv0=%b rd1=%h, required 1 0 %h", rvalid1, rvalid0, rdata1, mem_model(12'h060));
        end
        cyc(); cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        test_reset();
        test_write();
        test_read1();
        test_tie();
        test_preempt();
        test_reset_mid();
        test_handover();
        cyc();
        checks++;
        if (cmd_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain: cmd_q=%0d rd_q=%0d pending, required 0 0", cmd_q.size(), rd_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lmem_arbiter.md
LMEM_ARBITER -- requirements
Module: lmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 64, which sets the number of consecutive accepted commands after which an unlocked owner is preempted by a waiting requester.
REQ-002 SHALL have parameter ADDR_W, default 12, which sets the width of the layer-memory address.
REQ-003 SHALL have parameter DATA_W, default 20, which sets the width of the layer-memory data.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have, for n=0,1, inputs reqn_req (1), reqn_lock (1), reqn_wr (1), reqn_sel (3), reqn_addr (ADDR_W) and reqn_wdata (DATA_W): the client command bus; requester 0 is the CONV engine and requester 1 is the host readout.
REQ-007 SHALL have, for n=0,1, outputs gntn (1), rvalidn (1) and rdatan (DATA_W): the grant, read-return strobe and read data.
REQ-008 SHALL have memory-side outputs cwr (1), crd (1), csel (3), caddr_wr (ADDR_W), caddr_rd (ADDR_W) and cdata_wr (DATA_W), all registered.
REQ-009 SHALL have memory-side input cdata_rd (DATA_W), valid during the cycle in which crd is high.

Function
REQ-010 SHALL implement states IDLE, OWN0 and OWN1; gnt0=(state==OWN0) and gnt1=(state==OWN1), decoded from registers only.
REQ-011 SHALL transition IDLE to OWNn when only reqn_req is high; when both requests are high, SHALL select per REQ-025.
REQ-012 SHALL hold OWNn while reqn_req or reqn_lock is high and no preemption per REQ-014 occurs.
REQ-013 SHALL, in OWNn with reqn_req=0 and reqn_lock=0, go to OWN(1-n) if req(1-n)_req=1, else to IDLE.
REQ-014 SHALL preempt: in OWNn with reqn_lock=0, req(1-n)_req=1 and hold_cnt==MAX_HOLD-1 on an accepted command, go to OWN(1-n) next cycle.
REQ-015 SHALL keep hold_cnt at 0 in IDLE and on any state change, increment it per accepted command, and saturate it at MAX_HOLD-1.
REQ-016 SHALL treat a command as accepted at cycle T iff gntn=1 and reqn_req=1 at T; commands issued without grant are ignored and SHALL be held by the client.
REQ-017 SHALL, at T+1 after an accepted write, drive cwr=1, crd=0, csel=reqn_sel, caddr_wr=reqn_addr and cdata_wr=reqn_wdata.
REQ-018 SHALL, at T+1 after an accepted read, drive crd=1, cwr=0, csel=reqn_sel and caddr_rd=reqn_addr.
REQ-019 SHALL deassert cwr and crd in any cycle following a non-accepted cycle; csel, caddr_wr, caddr_rd and cdata_wr SHALL hold their last values.
REQ-020 SHALL capture cdata_rd at the end of T+1 and, at T+2, assert rvalidn for exactly 1 cycle with rdatan=the captured value; the read-return tag SHALL stay with the issuing requester even if ownership changes at T+1.
REQ-021 SHALL sustain 1 accepted command per cycle per owner; ownership switch latency SHALL be 1 cycle with no dead cycle.
REQ-022 SHALL never assert both gnt0 and gnt1, and never assert both cwr and crd.

Reset
REQ-023 SHALL, while reset is high, force state=IDLE, hold_cnt=0, gnt0=gnt1=0, cwr=crd=0, csel=0, caddr_wr=caddr_rd=0, cdata_wr=0, rvalid0=rvalid1=0 and rdata0=rdata1=0.
REQ-024 SHALL drop any in-flight read on reset mid-operation, with no rvalid issued after deassertion; arbitration SHALL resume from IDLE on the first clk edge after release.

Configuration
REQ-025 SHALL select arbitration with macro LMEM_ARB_RR_EN: when defined, the IDLE tie-break SHALL be round-robin, favouring the requester not granted most recently (initially requester 0 after reset); when undefined, requester 0 SHALL always win the IDLE tie-break. The REQ-014 preemption SHALL be present in both builds.

Verification
REQ-026 SHALL cover this scenario: req0 writes addr 0x005, data 0x00ABC, sel 3'b001 -> one cycle later cwr=1, caddr_wr=0x005, cdata_wr=0x00ABC, csel=3'b001.
REQ-027 SHALL cover this scenario: req1 reads addr 0x3FF while the memory model returns 0x12345 -> rvalid1 pulses at T+2 with rdata1=0x12345, and rvalid0 stays 0.
REQ-028 SHALL cover this scenario: req0 and req1 are both raised from IDLE, twice with releases in between -> without the macro, gnt0 wins twice; with LMEM_ARB_RR_EN, gnt0 wins then gnt1 wins.
REQ-029 SHALL cover this scenario: req0 streams unlocked while req1 waits, MAX_HOLD=4 -> exactly 4 req0 commands are accepted, then gnt1 asserts the next cycle; with req0_lock=1, gnt0 holds indefinitely.
REQ-030 SHALL cover this scenario: reset is pulsed one cycle after an accepted read -> no rvalid follows, all outputs read 0, and state is IDLE.
REQ-031 SHALL cover this scenario: owner 0 issues a read and drops req0 in the same cycle that req1 is high -> gnt1 asserts at T+1 and rvalid0, not rvalid1, pulses at T+2.
